// File: rtl/vga_timing_if.sv
// Raster timing bundle from vga_timing_gen to the renderers and VGA pins.
// sprite_addr exists only when VGA_SPRITE_ADDR_EN is defined.
interface vga_timing_if;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic        blank;
  logic        hs;
  logic        vs;
  logic        frame_start;
  logic        line_start;
`ifdef VGA_SPRITE_ADDR_EN
  logic [16:0] sprite_addr;

  modport master (output DrawX, DrawY, blank, hs, vs, frame_start, line_start, sprite_addr);
  modport slave  (input  DrawX, DrawY, blank, hs, vs, frame_start, line_start, sprite_addr);
`else
  modport master (output DrawX, DrawY, blank, hs, vs, frame_start, line_start);
  modport slave  (input  DrawX, DrawY, blank, hs, vs, frame_start, line_start);
`endif
endinterface

// File: rtl/vga_timing_gen.sv
// 640x480@60Hz raster timing master: counters, blank/start strobes, delayed hs/vs.
// Optional half-resolution sprite ROM address enabled by VGA_SPRITE_ADDR_EN.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int SYNC_DLY  = 1
`ifdef VGA_SPRITE_ADDR_EN
  ,
  parameter int SPR_W     = 320
`endif
) (
  input logic             vga_clk,
  input logic             reset_n,
  vga_timing_if.master    vga
);

  localparam logic [9:0] H_LAST   = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] V_LAST   = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [9:0] hc;
  logic [9:0] vc;
  logic       hs_raw;
  logic       vs_raw;

  // Stage p0: raster counters
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      hc <= '0;
      vc <= '0;
    end else if (hc == H_LAST) begin
      hc <= '0;
      vc <= (vc == V_LAST) ? 10'd0 : vc + 10'd1;
    end else begin
      hc <= hc + 10'd1;
    end
  end

  assign vga.DrawX       = hc;
  assign vga.DrawY       = vc;
  assign vga.blank       = reset_n && (hc < H_VIS) && (vc < V_VIS);
  assign vga.frame_start = reset_n && (hc == 10'd0) && (vc == 10'd0);
  assign vga.line_start  = reset_n && (hc == 10'd0) && (vc < V_VIS);

  assign hs_raw = !((hc >= HS_START) && (hc < HS_END));
  assign vs_raw = !((vc >= VS_START) && (vc < VS_END));

  // Stage p1..pN: sync delay line, reloaded with idle-high so no partial pulse survives reset
  generate
    if (SYNC_DLY == 0) begin : g_sync_comb
      assign vga.hs = hs_raw;
      assign vga.vs = vs_raw;
    end else begin : g_sync_dly
      logic [SYNC_DLY-1:0] hs_dly_p;
      logic [SYNC_DLY-1:0] vs_dly_p;

      always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
          hs_dly_p <= '1;
          vs_dly_p <= '1;
        end else begin
          hs_dly_p[0] <= hs_raw;
          vs_dly_p[0] <= vs_raw;
          for (int i = 1; i < SYNC_DLY; i++) begin
            hs_dly_p[i] <= hs_dly_p[i-1];
            vs_dly_p[i] <= vs_dly_p[i-1];
          end
        end
      end

      assign vga.hs = hs_dly_p[SYNC_DLY-1];
      assign vga.vs = vs_dly_p[SYNC_DLY-1];
    end
  endgenerate

`ifdef VGA_SPRITE_ADDR_EN
  localparam logic [9:0]  H_VIS_LAST = 10'(H_VISIBLE - 1);
  localparam logic [16:0] SPR_STEP   = 17'(SPR_W);

  logic [16:0] row_base;
  logic [8:0]  col;

  // Address built incrementally: col = DrawX>>1, row_base = (DrawY>>1)*SPR_W
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      row_base <= '0;
      col      <= '0;
    end else begin
      if (hc >= H_VIS_LAST)
        col <= '0;
      else if (hc[0])
        col <= col + 9'd1;

      if (hc == H_LAST) begin
        if (vc == V_LAST)
          row_base <= '0;
        else if (vc[0])
          row_base <= row_base + SPR_STEP;
      end
    end
  end

  assign vga.sprite_addr = reset_n ? (row_base + {8'd0, col}) : 17'd0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: full-size raster (SYNC_DLY 1 and 0) plus a
// reduced raster instance for whole-frame period/count and vsync checks.
module tb_vga_timing_gen;

  logic vga_clk = 1'b0;
  logic reset_n;
  logic rst_s_n;

  always #5 vga_clk = ~vga_clk;

  vga_timing_if if_d1();
  vga_timing_if if_d0();
  vga_timing_if if_sm();

  vga_timing_gen #(.SYNC_DLY(1)) dut_d1 (
    .vga_clk (vga_clk),
    .reset_n (reset_n),
    .vga     (if_d1)
  );

  vga_timing_gen #(.SYNC_DLY(0)) dut_d0 (
    .vga_clk (vga_clk),
    .reset_n (reset_n),
    .vga     (if_d0)
  );

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .SYNC_DLY(2)
`ifdef VGA_SPRITE_ADDR_EN
    , .SPR_W(4)
`endif
  ) dut_sm (
    .vga_clk (vga_clk),
    .reset_n (rst_s_n),
    .vga     (if_sm)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Raw sync state at raster step kk (kk counted from reset release); idle before kk=0.
  function automatic bit hsync_on(int kk, int htot, int s, int w);
    if (kk < 0) return 1'b0;
    return ((kk % htot) >= s) && ((kk % htot) < s + w);
  endfunction

  function automatic bit vsync_on(int kk, int htot, int vtot, int s, int w);
    if (kk < 0) return 1'b0;
    return (((kk / htot) % vtot) >= s) && (((kk / htot) % vtot) < s + w);
  endfunction

  initial begin
    int mism_cnt, mism_blk, mism_hs1, mism_hs0, mism_spr;
    int hs_fall, hs_rise;
    logic hs_prev;
    int fs_last, blank_f0, ls_f0, vs_fall, vs_rise;
    logic vs_prev;

    reset_n = 1'b0;
    rst_s_n = 1'b0;
    repeat (5) @(negedge vga_clk);

    check_val("rst_drawx", if_d1.DrawX, 0);
    check_val("rst_drawy", if_d1.DrawY, 0);
    check_val("rst_blank", if_d1.blank, 0);
    check_val("rst_hs", if_d1.hs, 1);
    check_val("rst_vs", if_d1.vs, 1);
    check_val("rst_frame_start", if_d1.frame_start, 0);
    check_val("rst_line_start", if_d1.line_start, 0);
    check_val("rst_sm_hs", if_sm.hs, 1);
`ifdef VGA_SPRITE_ADDR_EN
    check_val("rst_sprite_addr", if_d1.sprite_addr, 0);
`endif

    reset_n = 1'b1;
    #1;
    check_val("rel_blank", if_d1.blank, 1);
    check_val("rel_frame_start", if_d1.frame_start, 1);
    check_val("rel_line_start", if_d1.line_start, 1);

    mism_cnt = 0; mism_blk = 0; mism_hs1 = 0; mism_hs0 = 0; mism_spr = 0;
    hs_fall = -1; hs_rise = -1; hs_prev = 1'b1;
    for (int k = 0; k < 3100; k++) begin
      int hcm, vcm;
      logic exp_blank;
      hcm = k % 800;
      vcm = k / 800;
      exp_blank = (hcm < 640) && (vcm < 480);
      if (if_d1.DrawX != 10'(hcm) || if_d1.DrawY != 10'(vcm) ||
          if_d0.DrawX != 10'(hcm) || if_d0.DrawY != 10'(vcm)) mism_cnt++;
      if (if_d1.blank != exp_blank ||
          if_d1.frame_start != (hcm == 0 && vcm == 0) ||
          if_d1.line_start != (hcm == 0 && vcm < 480)) mism_blk++;
      if (if_d1.hs != !hsync_on(k - 1, 800, 656, 96) || if_d1.vs != 1'b1) mism_hs1++;
      if (if_d0.hs != !hsync_on(k, 800, 656, 96) || if_d0.vs != 1'b1) mism_hs0++;
`ifdef VGA_SPRITE_ADDR_EN
      if (exp_blank && if_d1.sprite_addr != 17'((hcm >> 1) + (vcm >> 1) * 320)) mism_spr++;
      if (hcm == 0 && vcm == 0) check_val("spr_0_0", if_d1.sprite_addr, 0);
      if (hcm == 1 && vcm == 0) check_val("spr_1_0", if_d1.sprite_addr, 0);
      if (hcm == 2 && vcm == 1) check_val("spr_2_1", if_d1.sprite_addr, 1);
      if (hcm == 0 && vcm == 2) check_val("spr_0_2", if_d1.sprite_addr, 320);
      if (hcm == 639 && vcm == 2) check_val("spr_639_2", if_d1.sprite_addr, 319 + 320);
`endif
      if (vcm == 0) begin
        if (hcm == 639) check_val("blank_639", if_d1.blank, 1);
        if (hcm == 640) check_val("blank_640", if_d1.blank, 0);
        if (hcm == 656) begin
          check_val("hs0_656", if_d0.hs, 0);
          check_val("hs1_656", if_d1.hs, 1);
        end
        if (hcm == 752) begin
          check_val("hs0_752", if_d0.hs, 1);
          check_val("hs1_752", if_d1.hs, 0);
        end
      end
      if (hs_prev && !if_d1.hs && hs_fall < 0) hs_fall = k;
      if (!hs_prev && if_d1.hs && hs_rise < 0) hs_rise = k;
      hs_prev = if_d1.hs;
      @(negedge vga_clk);
    end
    check_val("track_counters", mism_cnt, 0);
    check_val("track_blank_strobes", mism_blk, 0);
    check_val("track_hs_dly1", mism_hs1, 0);
    check_val("track_hs_dly0", mism_hs0, 0);
`ifdef VGA_SPRITE_ADDR_EN
    check_val("track_sprite_addr", mism_spr, 0);
`endif
    check_val("hs1_fall_cycle", hs_fall, 657);
    check_val("hs1_low_width", hs_rise - hs_fall, 96);

    // Now at hc=700, vc=3: inside the hsync pulse
    check_val("pre_rst_hs1", if_d1.hs, 0);
    reset_n = 1'b0;
    @(negedge vga_clk);
    check_val("midrst_drawx", if_d1.DrawX, 0);
    check_val("midrst_drawy", if_d1.DrawY, 0);
    check_val("midrst_hs1", if_d1.hs, 1);
    check_val("midrst_hs0", if_d0.hs, 1);
    check_val("midrst_blank", if_d1.blank, 0);
`ifdef VGA_SPRITE_ADDR_EN
    check_val("midrst_sprite_addr", if_d1.sprite_addr, 0);
`endif
    reset_n = 1'b1;
    #1;
    check_val("midrst_rel_frame_start", if_d1.frame_start, 1);

    // Reduced raster: H_TOTAL=15, V_TOTAL=8, frame=120 clocks, SYNC_DLY=2
    @(negedge vga_clk);
    check_val("sm_rst_drawx", if_sm.DrawX, 0);
    check_val("sm_rst_vs", if_sm.vs, 1);
    rst_s_n = 1'b1;
    #1;
    mism_cnt = 0; mism_hs1 = 0; mism_spr = 0;
    fs_last = -1; blank_f0 = 0; ls_f0 = 0; vs_fall = -1; vs_rise = -1; vs_prev = 1'b1;
    for (int k = 0; k < 275; k++) begin
      int hcm, vcm;
      hcm = k % 15;
      vcm = (k / 15) % 8;
      if (if_sm.DrawX != 10'(hcm) || if_sm.DrawY != 10'(vcm) ||
          if_sm.blank != ((hcm < 8) && (vcm < 4))) mism_cnt++;
      if (if_sm.hs != !hsync_on(k - 2, 15, 10, 3) ||
          if_sm.vs != !vsync_on(k - 2, 15, 8, 5, 2)) mism_hs1++;
`ifdef VGA_SPRITE_ADDR_EN
      if (if_sm.blank && if_sm.sprite_addr != 17'((hcm >> 1) + (vcm >> 1) * 4)) mism_spr++;
`endif
      if (k < 120) begin
        if (if_sm.blank) blank_f0++;
        if (if_sm.line_start) ls_f0++;
      end
      if (if_sm.frame_start) begin
        if (fs_last >= 0) check_val("sm_frame_period", k - fs_last, 120);
        fs_last = k;
      end
      if (vs_prev && !if_sm.vs && vs_fall < 0) vs_fall = k;
      if (!vs_prev && if_sm.vs && vs_rise < 0) vs_rise = k;
      vs_prev = if_sm.vs;
      @(negedge vga_clk);
    end
    check_val("sm_track_counters", mism_cnt, 0);
    check_val("sm_track_sync", mism_hs1, 0);
`ifdef VGA_SPRITE_ADDR_EN
    check_val("sm_track_sprite_addr", mism_spr, 0);
`endif
    check_val("sm_last_frame_start", fs_last, 240);
    check_val("sm_blank_per_frame", blank_f0, 32);
    check_val("sm_line_starts", ls_f0, 4);
    check_val("sm_vs_fall_cycle", vs_fall, 77);
    check_val("sm_vs_low_width", vs_rise - vs_fall, 30);

    // Small raster now at hc=5, vc=2
    check_val("sm_pre_rst_drawy", if_sm.DrawY, 2);
    rst_s_n = 1'b0;
    @(negedge vga_clk);
    check_val("sm_midrst_drawx", if_sm.DrawX, 0);
    check_val("sm_midrst_drawy", if_sm.DrawY, 0);
    check_val("sm_midrst_hs", if_sm.hs, 1);
`ifdef VGA_SPRITE_ADDR_EN
    check_val("sm_midrst_sprite_addr", if_sm.sprite_addr, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
